// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one multi-cycle main memory between the I-cache and D-cache miss
// handlers. Each side asks for either a line fill or (D only) a single-word
// write. The arbiter picks one owner, issues the reads or the write on the
// memory port, and steers the returning words back to the owner.
//
// Handshake: a side raises req and holds it until its done pulse. A request
// is only looked at while the arbiter is IDLE. gnt is high from the first
// issue cycle through done. rvalid qualifies rdata/widx for the owner, and
// done pulses with the last rvalid of a fill (or in the single write cycle).
// Dropping req or changing the address after the grant has no effect.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   i_req, i_addr         I-cache fill request and address
//   i_gnt, i_rvalid, i_done
//   d_req, d_wr, d_addr, d_wdata   D-cache request (d_wr=1 single write)
//   d_gnt, d_rvalid, d_done
//   rdata, widx           returned word and its index within the line
//   mem_enable, mem_wr, mem_addr, mem_wdata   memory request port
//   mem_rdata, mem_data_valid                 memory return port
//
// Configuration macro
//   MEM_ARB_ROUND_ROBIN_EN  defined: ties go to the side not granted last.
//                           undefined: D always beats I.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req,
    input  logic [15:0]      i_addr,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic             i_done,
    input  logic             d_req,
    input  logic             d_wr,
    input  logic [15:0]      d_addr,
    input  logic [15:0]      d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic             d_done,
    output logic [15:0]      rdata,
    output logic [IDX_W-1:0] widx,
    output logic             mem_enable,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_data_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Counters carry one extra bit so that LINE_WORDS itself is representable
    // and the issue counter can park there without wrapping.
    localparam int               CNT_W     = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LINE_WORDS - 1);
    // Clears the byte offset within a line (2 bytes per word).
    localparam logic [15:0]      LINE_MASK = ~16'((2 * LINE_WORDS) - 1);

    state_t           state;
    state_t           state_nxt;
    logic             owner_d;     // 1: D owns the current fill
    logic [15:0]      addr_q;      // line base for a fill, word address for a write
    logic [15:0]      wdata_q;
    logic [CNT_W-1:0] iss_cnt;
    logic [CNT_W-1:0] rcv_cnt;

    logic             req_any;
    logic             win_d;
    logic             issuing;
    logic             rd_take;
    logic             rd_last;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic             last_d;      // 1: D was granted most recently
`endif

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    assign req_any = i_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie, the side that did not win last time goes first.
    assign win_d = d_req & (~i_req | ~last_d);
`else
    assign win_d = d_req;
`endif

    // ---------------------------------------------------------------------
    // Fill datapath qualifiers
    // ---------------------------------------------------------------------
    assign issuing = (state == FILL) && (iss_cnt < CNT_FULL);
    // Returns outside FILL, or beyond the line, are dropped here.
    assign rd_take = (state == FILL) && mem_data_valid && (rcv_cnt < CNT_FULL);
    assign rd_last = rd_take && (rcv_cnt == CNT_LAST);

    // ---------------------------------------------------------------------
    // State register and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            iss_cnt <= '0;
            rcv_cnt <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        owner_d <= win_d;
                        iss_cnt <= '0;
                        rcv_cnt <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_d  <= win_d;
`endif
                        if (win_d && d_wr) begin
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                        end else if (win_d) begin
                            addr_q  <= d_addr & LINE_MASK;
                        end else begin
                            addr_q  <= i_addr & LINE_MASK;
                        end
                    end
                end
                FILL: begin
                    if (issuing) begin
                        iss_cnt <= iss_cnt + 1'b1;
                    end
                    if (rd_take) begin
                        rcv_cnt <= rcv_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = (win_d && d_wr) ? WRITE : FILL;
                end
            end
            FILL: begin
                if (rd_last) begin
                    state_nxt = IDLE;
                end
            end
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs: combinational from state and counters
    // ---------------------------------------------------------------------
    always_comb begin
        i_gnt      = 1'b0;
        i_rvalid   = 1'b0;
        i_done     = 1'b0;
        d_gnt      = 1'b0;
        d_rvalid   = 1'b0;
        d_done     = 1'b0;
        widx       = '0;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            FILL: begin
                i_gnt    = ~owner_d;
                d_gnt    = owner_d;
                i_rvalid = rd_take & ~owner_d;
                d_rvalid = rd_take & owner_d;
                i_done   = rd_last & ~owner_d;
                d_done   = rd_last & owner_d;
                if (rd_take) begin
                    widx = rcv_cnt[IDX_W-1:0];
                end
                if (issuing) begin
                    mem_enable = 1'b1;
                    mem_addr   = addr_q + (16'(iss_cnt) << 1);
                end
            end
            WRITE: begin
                d_gnt      = 1'b1;
                d_done     = 1'b1;
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
            end
            default: begin
            end
        endcase
    end

    assign rdata = mem_rdata;

endmodule
